// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and writeback source ids
package regfile_pkg;
   localparam int ADW  = 5;
   localparam int DW   = 32;
   localparam int NREG = 2 ** ADW;
   typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;
endpackage

// File: rtl/wb_prio_arb.sv
// wb_prio_arb: src0-priority arbiter that hands src1 the port after STARVE_MAX straight losses
module wb_prio_arb import regfile_pkg::*; #(
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic [3:0] starve_cnt;
   logic       force1;
   // src1 wins when it is starved, otherwise only when src0 is idle
   always_comb begin
      force1    = starve_cnt == 4'(STARVE_MAX);
      gnt[SRC1] = req[SRC1] & (force1 | ~req[SRC0]);
      gnt[SRC0] = req[SRC0] & ~gnt[SRC1];
   end
   // count consecutive src1 losses, saturating at STARVE_MAX
   always_ff @(posedge clk) begin
      if (reset || !req[SRC1] || gnt[SRC1]) starve_cnt <= '0;
      else if (gnt[SRC0] && !force1) starve_cnt <= starve_cnt + 4'd1;
   end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-port scheduler, busy scoreboard and issue stall for the 32x32 regfile
module regfile_wb_sched import regfile_pkg::*; #(
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            iss_valid,
   input  logic [ADW-1:0]  iss_rs,
   input  logic [ADW-1:0]  iss_rt,
   input  logic [ADW-1:0]  iss_rd,
   input  logic            iss_wen,
   output logic            iss_stall,
   input  logic            wb0_valid,
   input  logic [ADW-1:0]  wb0_addr,
   input  logic [DW-1:0]   wb0_data,
   output logic            wb0_ready,
   input  logic            wb1_valid,
   input  logic [ADW-1:0]  wb1_addr,
   input  logic [DW-1:0]   wb1_data,
   output logic            wb1_ready,
   output logic [ADW-1:0]  rf_a3,
   output logic [DW-1:0]   rf_wr,
   output logic            rf_wrenable,
   output logic [NREG-1:0] busy_vec,
   output logic            wb_err
);
   logic [1:0]      gnt;
   logic            hs;
   logic            reserve;
   logic [ADW-1:0]  hs_addr;
   logic [DW-1:0]   hs_data;
   logic [NREG-1:0] set_m;
   logic [NREG-1:0] clr_m;

   wb_prio_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({wb1_valid, wb0_valid}),
      .gnt   (gnt)
   );

   // stall from registered busy bits only, pick the winning source, build set/clear masks
   always_comb begin
      iss_stall = iss_valid & (busy_vec[iss_rs] | busy_vec[iss_rt] | (iss_wen & busy_vec[iss_rd]));
      reserve   = iss_valid & ~iss_stall & iss_wen & (iss_rd != '0);
      wb0_ready = gnt[SRC0];
      wb1_ready = gnt[SRC1];
      hs        = |gnt;
      hs_addr   = gnt[SRC1] ? wb1_addr : wb0_addr;
      hs_data   = gnt[SRC1] ? wb1_data : wb0_data;
      set_m     = reserve ? (NREG'(1) << iss_rd) : '0;
      clr_m     = rf_wrenable ? (NREG'(1) << rf_a3) : '0;
   end

   // scoreboard (set beats clear), output write stage and sticky protocol error
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_vec    <= '0;
         rf_a3       <= '0;
         rf_wr       <= '0;
         rf_wrenable <= 1'b0;
         wb_err      <= 1'b0;
      end else begin
         busy_vec    <= (busy_vec & ~clr_m) | set_m;
         rf_wrenable <= hs & (hs_addr != '0);
         if (hs) begin
            rf_a3 <= hs_addr;
            rf_wr <= hs_data;
         end
         if (hs && hs_addr != '0 && !busy_vec[hs_addr]) wb_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
   import regfile_pkg::*;
   logic            clk = 1'b0;
   logic            reset;
   logic            iss_valid, iss_wen, iss_stall;
   logic [ADW-1:0]  iss_rs, iss_rt, iss_rd;
   logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
   logic [ADW-1:0]  wb0_addr, wb1_addr, rf_a3;
   logic [DW-1:0]   wb0_data, wb1_data, rf_wr;
   logic            rf_wrenable, wb_err;
   logic [NREG-1:0] busy_vec;
   int              checks = 0;
   int              errors = 0;

   regfile_wb_sched #(.STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd),
      .iss_wen(iss_wen), .iss_stall(iss_stall),
      .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_a3(rf_a3), .rf_wr(rf_wr), .rf_wrenable(rf_wrenable),
      .busy_vec(busy_vec), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input int rs, input int rt, input int rd, input logic wen);
      iss_valid = v;
      iss_rs    = ADW'(rs);
      iss_rt    = ADW'(rt);
      iss_rd    = ADW'(rd);
      iss_wen   = wen;
   endtask

   initial begin
      reset = 1'b1;
      issue(0, 0, 0, 0, 0);
      wb0_valid = 0; wb0_addr = '0; wb0_data = '0;
      wb1_valid = 0; wb1_addr = '0; wb1_data = '0;
      step(); step();
      reset = 1'b0;
      // reset state and clean issue
      issue(1, 3, 4, 0, 0);
      #1;
      chk("rst_busy", 64'(busy_vec), 0);
      chk("rst_wren", 64'(rf_wrenable), 0);
      chk("rst_err", 64'(wb_err), 0);
      chk("rst_a3", 64'(rf_a3), 0);
      chk("rst_stall", 64'(iss_stall), 0);
      // RAW: reserve r5
      issue(1, 0, 0, 5, 1);
      #1 chk("raw_res_stall", 64'(iss_stall), 0);
      step();
      issue(1, 5, 0, 0, 0);
      wb0_valid = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF;
      #1;
      chk("raw_busy", 64'(busy_vec), 64'h20);
      chk("raw_stall_t", 64'(iss_stall), 1);
      chk("raw_wb0_rdy", 64'(wb0_ready), 1);
      step();
      wb0_valid = 0;
      #1;
      chk("raw_wren", 64'(rf_wrenable), 1);
      chk("raw_a3", 64'(rf_a3), 5);
      chk("raw_wr", 64'(rf_wr), 64'hDEADBEEF);
      chk("raw_stall_t1", 64'(iss_stall), 1);
      step();
      #1;
      chk("raw_stall_t2", 64'(iss_stall), 0);
      chk("raw_busy_clr", 64'(busy_vec), 0);
      chk("raw_err", 64'(wb_err), 0);
      // WAW stall through rd only
      issue(1, 0, 0, 6, 1);
      step();
      issue(1, 0, 0, 6, 1);
      #1 chk("waw_stall", 64'(iss_stall), 1);
      issue(1, 0, 0, 6, 0);
      #1 chk("waw_nowen", 64'(iss_stall), 0);
      // $0 writeback from src1 while r6 is reserved
      issue(0, 0, 0, 0, 0);
      wb1_valid = 1; wb1_addr = 0; wb1_data = 32'h1234;
      #1;
      chk("z_wb1_rdy", 64'(wb1_ready), 1);
      chk("z_wb0_rdy", 64'(wb0_ready), 0);
      step();
      wb1_valid = 0;
      #1;
      chk("z_wren", 64'(rf_wrenable), 0);
      chk("z_busy", 64'(busy_vec), 64'h40);
      chk("z_err", 64'(wb_err), 0);
      // release r6
      wb0_valid = 1; wb0_addr = 6; wb0_data = 32'h66;
      step();
      wb0_valid = 0;
      step();
      #1;
      chk("r6_busy", 64'(busy_vec), 0);
      chk("r6_err", 64'(wb_err), 0);
      // contention: 4x src0 then 1x src1, repeating
      wb0_valid = 1; wb0_addr = 0;
      wb1_valid = 1; wb1_addr = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("cont_g1_%0d", i), 64'(wb1_ready), 64'((i % 5) == 4));
         chk($sformatf("cont_g0_%0d", i), 64'(wb0_ready), 64'((i % 5) != 4));
         step();
      end
      wb0_valid = 0; wb1_valid = 0;
      step();
      // protocol error: write r7 while not busy
      wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h77;
      step();
      wb0_valid = 0;
      #1;
      chk("err_wren", 64'(rf_wrenable), 1);
      chk("err_a3", 64'(rf_a3), 7);
      chk("err_set", 64'(wb_err), 1);
      step(); step();
      #1 chk("err_sticky", 64'(wb_err), 1);
      // reset mid-operation while src1 is granted for reserved r9
      issue(1, 0, 0, 9, 1);
      step();
      issue(0, 0, 0, 0, 0);
      wb1_valid = 1; wb1_addr = 9; wb1_data = 32'h99;
      reset = 1'b1;
      #1;
      chk("mid_busy9", 64'(busy_vec), 64'h200);
      chk("mid_wb1_rdy", 64'(wb1_ready), 1);
      step();
      reset = 1'b0;
      wb1_valid = 0;
      #1;
      chk("mid_wren", 64'(rf_wrenable), 0);
      chk("mid_busy", 64'(busy_vec), 0);
      chk("mid_err", 64'(wb_err), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
